// File: rtl/apb_master_if.sv
// Purpose : command/response and APB bus bundle for apb_master.
// Latency : n/a (wires only).
// Backpressure: cmd side is valid/ready; rsp side has no backpressure.
//
// Ports (signals carried):
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata : command request
//   rsp_valid/rsp_rdata/rsp_err/rsp_timeout          : one-cycle response
//   paddr/pselx/penable/pwrite/pwdata/prdata/pready/pslverr : APB bus
// Modports: master = the requester (apb_master), slave = the environment
// that issues commands, consumes responses and acts as the APB completer.
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] paddr;
  logic              pselx;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output paddr, pselx, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  paddr, pselx, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_master.sv
// Purpose : APB requester; turns valid/ready commands into APB SETUP/ACCESS
//           transfers and returns one registered response per command.
// Latency : accept at edge N -> SETUP N+1 -> ACCESS N+2 -> rsp_valid N+3
//           (plus one cycle per wait state); back-to-back: 1 transfer / 2 cycles.
// Backpressure: cmd_ready only in IDLE or on the completing ACCESS cycle;
//           responses cannot be stalled.
//
// Ports:
//   pclk  - clock, rising edge
//   prst  - synchronous active-high reset
//   bus   - apb_master_if.master: command, response and APB signals
//
// Optional feature macro: APB_MASTER_TIMEOUT_EN
//   defined   : 8-bit wait-state counter; after TIMEOUT_CYCLES consecutive
//               ACCESS cycles with pready=0 the transfer is aborted and a
//               response with rsp_err=1, rsp_timeout=1 is issued.
//   undefined : no counter, rsp_timeout tied 0, ACCESS waits indefinitely.
module apb_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef APB_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic            pclk,
  input  logic            prst,
  apb_master_if.master    bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              cmd_ready;
  logic              cmd_accept;
  logic              xfer_done;

  // A new command may enter while idle, or in the very cycle the current
  // transfer completes so pselx can stay high across transfers.
  assign xfer_done  = (state_q == ST_ACCESS) && bus.pready;
  assign cmd_ready  = (state_q == ST_IDLE) || xfer_done;
  assign cmd_accept = bus.cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       rsp_timeout_q, rsp_timeout_d;
  logic       tmo_abort;

  assign tmo_abort = (state_q == ST_ACCESS) && !bus.pready &&
                     (wait_cnt_q == TMO_LAST);

  // Counts consecutive stalled ACCESS cycles of the current transfer.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d == ST_SETUP) begin
      wait_cnt_d = 8'd0;
    end else if ((state_q == ST_ACCESS) && !bus.pready) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      wait_cnt_q    <= 8'd0;
      rsp_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.rsp_timeout = rsp_timeout_q;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout_q;
`endif

    case (state_q)
      ST_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (cmd_accept) begin
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          pwdata_d = bus.cmd_wdata;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (bus.pready) begin
          // prdata/pslverr are only meaningful in this cycle.
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.pslverr;
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          if (cmd_accept) begin
            paddr_d   = bus.cmd_addr;
            pwrite_d  = bus.cmd_write;
            pwdata_d  = bus.cmd_wdata;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            state_d   = ST_SETUP;
          end else begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (tmo_abort) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end
`endif
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.pselx     = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
